// File: rtl/decoder_seq_sel.sv
// rtl/decoder_seq_sel.sv - registered one-hot select decoder with dwell timing and scan sequencing
module decoder_seq_sel #(
   parameter int SEL_W   = 4,
   parameter int NUM_OUT = 16,
   parameter int DWELL   = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               scan_mode,
   input  logic [SEL_W-1:0]   sel_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [NUM_OUT-1:0] dec_out,
   output logic               out_valid,
   output logic [SEL_W-1:0]   scan_idx,
   output logic               wrap,
   output logic               sel_err
);

   localparam int               CNT_W     = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] DWELL_C   = CNT_W'(DWELL);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [SEL_W:0]   NUM_OUT_C = (SEL_W + 1)'(NUM_OUT);
   localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NUM_OUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SCAN
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_OUT-1:0] dec_q, dec_d;
   logic               out_valid_q, out_valid_d;
   logic [SEL_W-1:0]   idx_q, idx_d;
   logic               wrap_q, wrap_d;
   logic               sel_err_q, sel_err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               sel_ok;
   logic               dwell_done;
   logic               at_last;
   logic [SEL_W-1:0]   next_idx;

   // Only indices below NUM_OUT can ever produce a set bit.
   function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] idx);
      logic [NUM_OUT-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_OUT; i++) begin
         if (idx == SEL_W'(i)) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   assign sel_ok     = ({1'b0, sel_in} < NUM_OUT_C);
   assign dwell_done = (cnt_q == DWELL_C);
   assign at_last    = (idx_q == LAST_IDX);
   assign next_idx   = at_last ? '0 : idx_q + 1'b1;

   assign in_ready   = (state_q == ST_IDLE) & en & ~scan_mode;

   assign dec_out    = dec_q;
   assign out_valid  = out_valid_q;
   assign scan_idx   = idx_q;
   assign wrap       = wrap_q;
   assign sel_err    = sel_err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         dec_q       <= '0;
         out_valid_q <= 1'b0;
         idx_q       <= '0;
         wrap_q      <= 1'b0;
         sel_err_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         dec_q       <= dec_d;
         out_valid_q <= out_valid_d;
         idx_q       <= idx_d;
         wrap_q      <= wrap_d;
         sel_err_q   <= sel_err_d;
         cnt_q       <= cnt_d;
      end
   end

   // cnt_q is the number of cycles the current output has already been shown.
   always_comb begin
      state_d     = state_q;
      dec_d       = dec_q;
      out_valid_d = out_valid_q;
      idx_d       = idx_q;
      wrap_d      = 1'b0;
      sel_err_d   = 1'b0;
      cnt_d       = cnt_q;

      if (!en) begin
         state_d     = ST_IDLE;
         dec_d       = '0;
         out_valid_d = 1'b0;
         cnt_d       = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               dec_d       = '0;
               out_valid_d = 1'b0;
               cnt_d       = '0;
               if (scan_mode) begin
                  state_d     = ST_SCAN;
                  dec_d       = onehot('0);
                  idx_d       = '0;
                  out_valid_d = 1'b1;
                  cnt_d       = CNT_ONE;
               end else if (in_valid) begin
                  if (sel_ok) begin
                     state_d     = ST_HOLD;
                     dec_d       = onehot(sel_in);
                     idx_d       = sel_in;
                     out_valid_d = 1'b1;
                     cnt_d       = CNT_ONE;
                  end else begin
                     sel_err_d = 1'b1;
                  end
               end
            end

            ST_HOLD: begin
               if (dwell_done) begin
                  state_d     = ST_IDLE;
                  dec_d       = '0;
                  out_valid_d = 1'b0;
                  cnt_d       = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_SCAN: begin
               // scan_mode is only honoured at a dwell boundary so no index is cut short.
               if (dwell_done) begin
                  if (!scan_mode) begin
                     state_d     = ST_IDLE;
                     dec_d       = '0;
                     out_valid_d = 1'b0;
                     cnt_d       = '0;
                  end else begin
                     idx_d  = next_idx;
                     dec_d  = onehot(next_idx);
                     wrap_d = at_last;
                     cnt_d  = CNT_ONE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            default: begin
               state_d     = ST_IDLE;
               dec_d       = '0;
               out_valid_d = 1'b0;
               cnt_d       = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_seq_sel.sv
// tb/tb_decoder_seq_sel.sv - directed bench for decoder_seq_sel across four parameter sets
module tb_decoder_seq_sel;

   logic clk;
   logic rst;

   // A: defaults (DWELL=1, NUM_OUT=16)
   logic en_a, sm_a, v_a, rdy_a, ov_a, wrap_a, err_a;
   logic [3:0]  sel_a, idx_a;
   logic [15:0] dec_a;
   // B: DWELL=3, NUM_OUT=16
   logic en_b, sm_b, v_b, rdy_b, ov_b, wrap_b, err_b;
   logic [3:0]  sel_b, idx_b;
   logic [15:0] dec_b;
   // C: DWELL=1, NUM_OUT=10
   logic en_c, sm_c, v_c, rdy_c, ov_c, wrap_c, err_c;
   logic [3:0]  sel_c, idx_c;
   logic [9:0]  dec_c;
   // D: DWELL=2, NUM_OUT=4
   logic en_d, sm_d, v_d, rdy_d, ov_d, wrap_d, err_d;
   logic [3:0]  sel_d, idx_d;
   logic [3:0]  dec_d;

   decoder_seq_sel u_a (
      .clk(clk), .rst(rst), .en(en_a), .scan_mode(sm_a), .sel_in(sel_a), .in_valid(v_a),
      .in_ready(rdy_a), .dec_out(dec_a), .out_valid(ov_a), .scan_idx(idx_a), .wrap(wrap_a),
      .sel_err(err_a));

   decoder_seq_sel #(.SEL_W(4), .NUM_OUT(16), .DWELL(3)) u_b (
      .clk(clk), .rst(rst), .en(en_b), .scan_mode(sm_b), .sel_in(sel_b), .in_valid(v_b),
      .in_ready(rdy_b), .dec_out(dec_b), .out_valid(ov_b), .scan_idx(idx_b), .wrap(wrap_b),
      .sel_err(err_b));

   decoder_seq_sel #(.SEL_W(4), .NUM_OUT(10), .DWELL(1)) u_c (
      .clk(clk), .rst(rst), .en(en_c), .scan_mode(sm_c), .sel_in(sel_c), .in_valid(v_c),
      .in_ready(rdy_c), .dec_out(dec_c), .out_valid(ov_c), .scan_idx(idx_c), .wrap(wrap_c),
      .sel_err(err_c));

   decoder_seq_sel #(.SEL_W(4), .NUM_OUT(4), .DWELL(2)) u_d (
      .clk(clk), .rst(rst), .en(en_d), .scan_mode(sm_d), .sel_in(sel_d), .in_valid(v_d),
      .in_ready(rdy_d), .dec_out(dec_d), .out_valid(ov_d), .scan_idx(idx_d), .wrap(wrap_d),
      .sel_err(err_d));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        en;
      logic        sm;
      logic        v;
      logic [3:0]  sel;
      logic        rdy;
      logic [15:0] dec;
      logic        ov;
      logic [3:0]  idx;
      logic        wrap;
      logic        err;
   } vec_t;

   vec_t tbl[12];
   int   n_err;
   int   n_chk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic step_d(input string nm, input logic [3:0] edec, input logic [3:0] eidx,
                         input logic ewrap);
      tick();
      chk({nm, " dec"}, 32'(dec_d), 32'(edec));
      chk({nm, " ov"}, 32'(ov_d), 32'(edec != 4'd0));
      if (edec != 4'd0) chk({nm, " idx"}, 32'(idx_d), 32'(eidx));
      chk({nm, " wrap"}, 32'(wrap_d), 32'(ewrap));
   endtask

   logic [15:0] exp_b_dec[8];
   logic        exp_b_rdy[9];
   logic [3:0]  exp_d_dec[15];
   logic [3:0]  exp_d_idx[15];
   logic        exp_d_wrap[15];

   initial begin
      // fields: en sm v sel | rdy dec ov idx wrap err
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b1, 16'h0200, 1'b1, 4'd9,  1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 4'd9,  1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'd9,  1'b1, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'd15, 1'b1, 16'h8000, 1'b1, 4'd15, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 16'h0001, 1'b1, 4'd0,  1'b0, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd3,  1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd3,  1'b0, 16'h0001, 1'b1, 4'd0,  1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 16'h0002, 1'b1, 4'd1,  1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd3,  1'b0, 16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 1'b1, 4'd5,  1'b1, 16'h0020, 1'b1, 4'd5,  1'b0, 1'b0};

      exp_b_dec = '{16'h0001, 16'h0001, 16'h0001, 16'h0000, 16'h8000, 16'h8000, 16'h8000, 16'h0000};
      exp_b_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      exp_d_dec  = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h0};
      exp_d_idx  = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0};
      exp_d_wrap = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      n_err = 0;
      n_chk = 0;
      en_a = 0; sm_a = 0; v_a = 0; sel_a = 0;
      en_b = 0; sm_b = 0; v_b = 0; sel_b = 0;
      en_c = 0; sm_c = 0; v_c = 0; sel_c = 0;
      en_d = 0; sm_d = 0; v_d = 0; sel_d = 0;
      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk("reset dec_a", 32'(dec_a), 32'h0);
      chk("reset ov_a", 32'(ov_a), 32'h0);
      chk("reset idx_a", 32'(idx_a), 32'h0);
      chk("reset wrap_d", 32'(wrap_d), 32'h0);
      chk("reset err_c", 32'(err_c), 32'h0);
      chk("reset dec_d", 32'(dec_d), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();

      // Table-driven single-cycle decode on the default configuration
      for (int i = 0; i < 12; i++) begin
         en_a = tbl[i].en; sm_a = tbl[i].sm; v_a = tbl[i].v; sel_a = tbl[i].sel;
         #1;
         chk($sformatf("tbl%0d rdy", i), 32'(rdy_a), 32'(tbl[i].rdy));
         tick();
         chk($sformatf("tbl%0d dec", i), 32'(dec_a), 32'(tbl[i].dec));
         chk($sformatf("tbl%0d ov", i), 32'(ov_a), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d wrap", i), 32'(wrap_a), 32'(tbl[i].wrap));
         chk($sformatf("tbl%0d err", i), 32'(err_a), 32'(tbl[i].err));
         if (tbl[i].ov) chk($sformatf("tbl%0d idx", i), 32'(idx_a), 32'(tbl[i].idx));
      end
      en_a = 0; v_a = 0;

      // DWELL=3: back-to-back selects held valid are spaced DWELL+1 cycles
      en_b = 1; v_b = 1; sel_b = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (i == 1) sel_b = 4'd15;
         if (i == 7) v_b = 0;
         #1;
         chk($sformatf("dwell3 rdy%0d", i), 32'(rdy_b), 32'(exp_b_rdy[i]));
         tick();
         chk($sformatf("dwell3 dec%0d", i), 32'(dec_b), 32'(exp_b_dec[i]));
         chk($sformatf("dwell3 ov%0d", i), 32'(ov_b), 32'(exp_b_dec[i] != 16'h0));
      end
      chk("dwell3 rdy8", 32'(rdy_b), 32'(exp_b_rdy[8]));

      // en low in the second cycle of a hold drops the output next cycle
      v_b = 1; sel_b = 4'd6;
      tick();
      chk("enlow hold c1", 32'(dec_b), 32'h0040);
      v_b = 0;
      tick();
      chk("enlow hold c2", 32'(dec_b), 32'h0040);
      en_b = 0;
      #1 chk("enlow hold rdy", 32'(rdy_b), 32'h0);
      tick();
      chk("enlow hold dec", 32'(dec_b), 32'h0);
      chk("enlow hold ov", 32'(ov_b), 32'h0);
      v_b = 1; sel_b = 4'd2;
      #1 chk("enlow hold rdy2", 32'(rdy_b), 32'h0);
      tick();
      chk("enlow hold stays 0", 32'(dec_b), 32'h0);
      en_b = 1;
      #1 chk("reenable rdy", 32'(rdy_b), 32'h1);
      tick();
      chk("reenable dec", 32'(dec_b), 32'h0004);
      chk("reenable idx", 32'(idx_b), 32'h2);
      v_b = 0;
      tick();
      chk("reenable dec2", 32'(dec_b), 32'h0004);
      tick();
      chk("reenable dec3", 32'(dec_b), 32'h0004);
      tick();
      chk("reenable end", 32'(dec_b), 32'h0);
      en_b = 0;

      // NUM_OUT=10: out-of-range selects raise sel_err only
      en_c = 1; v_c = 1; sel_c = 4'd10;
      #1 chk("err rdy", 32'(rdy_c), 32'h1);
      tick();
      chk("err10 pulse", 32'(err_c), 32'h1);
      chk("err10 dec", 32'(dec_c), 32'h0);
      chk("err10 ov", 32'(ov_c), 32'h0);
      sel_c = 4'd12;
      #1 chk("err rdy idle", 32'(rdy_c), 32'h1);
      tick();
      chk("err12 pulse", 32'(err_c), 32'h1);
      chk("err12 dec", 32'(dec_c), 32'h0);
      v_c = 0;
      tick();
      chk("err clears", 32'(err_c), 32'h0);
      v_c = 1; sel_c = 4'd9;
      tick();
      chk("sel9 dec", 32'(dec_c), 32'h200);
      chk("sel9 idx", 32'(idx_c), 32'h9);
      chk("sel9 err", 32'(err_c), 32'h0);
      v_c = 0;
      tick();
      chk("sel9 end", 32'(dec_c), 32'h0);
      en_c = 0;

      // SCAN with DWELL=2, NUM_OUT=4, scan_mode dropped mid index 2
      en_d = 1; sm_d = 1;
      for (int i = 0; i < 15; i++) begin
         if (i == 13) sm_d = 0;
         #1 chk($sformatf("scan rdy%0d", i), 32'(rdy_d), 32'h0);
         step_d($sformatf("scan e%0d", i + 1), exp_d_dec[i], exp_d_idx[i], exp_d_wrap[i]);
      end

      // en low mid-scan
      sm_d = 1;
      step_d("enlow scan e1", 4'h1, 4'd0, 1'b0);
      step_d("enlow scan e2", 4'h1, 4'd0, 1'b0);
      step_d("enlow scan e3", 4'h2, 4'd1, 1'b0);
      en_d = 0; sm_d = 0;
      #1 chk("enlow scan rdy", 32'(rdy_d), 32'h0);
      step_d("enlow scan off", 4'h0, 4'd0, 1'b0);
      step_d("enlow scan off2", 4'h0, 4'd0, 1'b0);
      en_d = 1; v_d = 1; sel_d = 4'd3;
      #1 chk("enlow scan rdy2", 32'(rdy_d), 32'h1);
      step_d("after scan sel3", 4'h8, 4'd3, 1'b0);
      v_d = 0;
      step_d("after scan sel3 b", 4'h8, 4'd3, 1'b0);
      step_d("after scan idle", 4'h0, 4'd0, 1'b0);

      // asynchronous reset mid-scan, then restart at index 0 with no wrap
      sm_d = 1;
      step_d("rst scan e1", 4'h1, 4'd0, 1'b0);
      step_d("rst scan e2", 4'h1, 4'd0, 1'b0);
      step_d("rst scan e3", 4'h2, 4'd1, 1'b0);
      step_d("rst scan e4", 4'h2, 4'd1, 1'b0);
      step_d("rst scan e5", 4'h4, 4'd2, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async rst dec", 32'(dec_d), 32'h0);
      chk("async rst idx", 32'(idx_d), 32'h0);
      chk("async rst ov", 32'(ov_d), 32'h0);
      #2 rst = 1'b0;
      step_d("post rst e1", 4'h1, 4'd0, 1'b0);
      step_d("post rst e2", 4'h1, 4'd0, 1'b0);
      step_d("post rst e3", 4'h2, 4'd1, 1'b0);
      en_d = 0; sm_d = 0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
